fsmd_divider: RTL and testbench

Sequential restoring divider FSMD that undoes the multiply step of the team's arithmetic FSMD datapath: it recovers an operand from a product. A 1-cycle `start` pulse launches an unsigned WIDTH-bit division. The block iterates one quotient bit per clock, then pulses `done` with registered quotient and remainder. It sits beside the multiply-accumulate FSMD as its inverse/check path, and exposes its present state for debug like the rest of the FSMD family.

---
 rtl/fsmd_pkg.sv | 12 +
 rtl/fsmd_div_step.sv | 31 +++
 rtl/fsmd_divider.sv | 119 +++++++++++
 tb/tb_fsmd_divider.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsmd_pkg.sv
// rtl/fsmd_pkg.sv - shared FSMD state encoding and default datapath width
package fsmd_pkg;

  localparam int FSMD_DEF_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_ITER = 3'b001,
    ST_DONE = 3'b010
  } fsmd_state_e;

endpackage

// File: rtl/fsmd_div_step.sv
// rtl/fsmd_div_step.sv - one combinational restoring-division step
module fsmd_div_step
  import fsmd_pkg::*;
#(
  parameter int WIDTH = FSMD_DEF_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bit_in,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic           unused_r_msb;

  // R stays below B between steps, so its top bit never carries information
  assign unused_r_msb = r_in[WIDTH];

  always_comb begin
    trial = {r_in[WIDTH-1:0], bit_in};
    if (trial >= {1'b0, b_in}) begin
      r_out = trial - {1'b0, b_in};
      q_bit = 1'b1;
    end else begin
      r_out = trial;
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/fsmd_divider.sv
// rtl/fsmd_divider.sv - sequential restoring divider FSMD; FSMD_DIV_ZERO_CHECK_EN enables zero-divisor shortcut
module fsmd_divider
  import fsmd_pkg::*;
#(
  parameter int WIDTH = FSMD_DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [2:0]       PS
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  fsmd_state_e      state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, b_q, b_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH:0]   step_r;
  logic             step_qbit;

  fsmd_div_step #(.WIDTH(WIDTH)) u_step (
    .r_in   (r_q),
    .b_in   (b_q),
    .bit_in (q_q[WIDTH-1]),
    .r_out  (step_r),
    .q_bit  (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d     = dividend;
          b_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = ST_ITER;
`ifdef FSMD_DIV_ZERO_CHECK_EN
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_ITER: begin
        q_d   = {q_q[WIDTH-2:0], step_qbit};
        r_d   = step_r;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          quot_d  = {q_q[WIDTH-2:0], step_qbit};
          rem_d   = step_r[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // status flags are registered copies of what the next state will be
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign PS          = state_q;

endmodule

// File: tb/tb_fsmd_divider.sv
// tb/tb_fsmd_divider.sv - scoreboard bench for fsmd_divider against an arithmetic reference model
module tb_fsmd_divider;

  localparam int W = 4;
`ifdef FSMD_DIV_ZERO_CHECK_EN
  localparam bit ZERO_CHK = 1'b1;
`else
  localparam bit ZERO_CHK = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [2:0]   PS;

  fsmd_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .PS          (PS)
  );

  always #5 clock = ~clock;

  typedef struct {
    int q;
    int r;
    int dbz;
    int done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int free_edge = 0;
  int acc_edge = -1;
  int done_edge = -1;
  int held_q = 0, held_r = 0, held_dbz = 0;
  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: decides acceptance and expected results from plain arithmetic
  initial forever begin
    exp_t e;
    int a, b;
    @(posedge clock);
    cyc++;
    if (!reset && start && cyc >= free_edge) begin
      a = int'(dividend);
      b = int'(divisor);
      if (b == 0) begin
        e.q = (1 << W) - 1;
        e.r = a;
        e.dbz = ZERO_CHK ? 1 : 0;
        e.done_cyc = ZERO_CHK ? cyc : cyc + W;
      end else begin
        e.q = a / b;
        e.r = a % b;
        e.dbz = 0;
        e.done_cyc = cyc + W;
      end
      acc_edge = cyc;
      done_edge = e.done_cyc;
      free_edge = e.done_cyc + 2;
      exp_q.push_back(e);
    end
  end

  // monitor: compares status every cycle and results whenever done is presented
  initial forever begin
    exp_t e;
    int exp_busy;
    @(negedge clock);
    if (reset) begin
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ps", int'(PS), 0);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_dbz", int'(div_by_zero), 0);
    end else begin
      exp_busy = (acc_edge >= 0 && cyc >= acc_edge && cyc <= done_edge) ? 1 : 0;
      check("busy", int'(busy), exp_busy);
      check("ps", int'(PS), exp_busy == 0 ? 0 : (cyc == done_edge ? 2 : 1));
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("quotient", int'(quotient), e.q);
          check("remainder", int'(remainder), e.r);
          check("div_by_zero", int'(div_by_zero), e.dbz);
          held_q = e.q;
          held_r = e.r;
          held_dbz = e.dbz;
        end
      end else begin
        if (exp_q.size() > 0 && cyc >= exp_q[0].done_cyc) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_done: got done=0 expected done=1 (cycle %0d)", cyc);
          held_q = e.q;
          held_r = e.r;
          held_dbz = e.dbz;
        end else begin
          check("hold_quotient", int'(quotient), held_q);
          check("hold_remainder", int'(remainder), held_r);
          check("hold_dbz", int'(div_by_zero), held_dbz);
        end
      end
    end
  end

  task automatic issue(input int a, input int b);
    @(negedge clock);
    while (cyc + 1 < free_edge) @(negedge clock);
    dividend = W'(a);
    divisor = W'(b);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dividend = W'($urandom_range(0, 15));
    divisor = W'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic reset_mid_flight();
    @(posedge clock);
    #2;
    reset = 1'b1;
    exp_q.delete();
    acc_edge = -1;
    done_edge = -1;
    free_edge = 0;
    held_q = 0;
    held_r = 0;
    held_dbz = 0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_ps", int'(PS), 0);
    check("async_rst_quotient", int'(quotient), 0);
    check("async_rst_remainder", int'(remainder), 0);
    check("async_rst_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;

    issue(13, 4);  drain();
    issue(15, 1);  drain();
    issue(0, 7);   drain();
    issue(6, 9);   drain();
    issue(7, 0);   drain();

    // start held high; operands change mid-division
    @(negedge clock);
    while (cyc + 1 < free_edge) @(negedge clock);
    dividend = 4'd9;
    divisor = 4'd2;
    start = 1'b1;
    repeat (2) @(negedge clock);
    dividend = 4'd8;
    divisor = 4'd3;
    repeat (5) @(negedge clock);
    start = 1'b0;
    drain();

    issue(12, 5);
    reset_mid_flight();
    repeat (3) @(negedge clock);
    issue(12, 5);  drain();

    repeat (20) @(negedge clock);

    for (int i = 0; i < 30; i++) begin
      if (i % 7 == 3) issue($urandom_range(0, 15), 0);
      else issue($urandom_range(0, 15), $urandom_range(0, 15));
    end
    drain();
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
